// File: rtl/key_event_gen.sv
// Per-key button conditioner: two-flop synchroniser, debounce FSM, one-cycle
// press/release pulses and typematic auto-repeat press pulses while held.
module key_event_gen #(
  parameter int N_KEYS          = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_RATE) ? CNT_MAX_A : REPEAT_RATE;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [N_KEYS-1:0] SYNC_IDLE = {N_KEYS{KEY_ACTIVE_LOW}};

  typedef enum logic [2:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_HELD,
    S_REPEAT,
    S_RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] raw;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= SYNC_IDLE;
      sync2_q <= SYNC_IDLE;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             level_q, level_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= S_RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        level_q   <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        level_q   <= level_d;
        repeat_q  <= repeat_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        S_RELEASED: begin
          if (raw[gi]) begin
            state_d = S_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!raw[gi]) begin
            state_d = S_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = S_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!raw[gi]) begin
            state_d = S_RELEASE_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == DLY_LAST) begin
            state_d = S_REPEAT;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!raw[gi]) begin
            state_d = S_RELEASE_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == RPT_LAST) begin
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE_WAIT: begin
          // A bounce back to pressed restarts the full repeat delay.
          if (raw[gi]) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = S_RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end
      endcase
      level_d  = (state_d == S_HELD) || (state_d == S_REPEAT) || (state_d == S_RELEASE_WAIT);
      repeat_d = (state_d == S_REPEAT);
    end

    assign key_press[gi]   = press_q;
    assign key_release[gi] = release_q;
    assign key_level[gi]   = level_q;
    assign key_repeat[gi]  = repeat_q;
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: expected pulse/level events are queued on stimulus
// and checked every cycle against all four output vectors.
module tb_key_event_gen;

  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RRATE = 3;
  localparam int P_LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;

  always #5 clk = ~clk;

  key_event_gen #(
    .N_KEYS          (4),
    .KEY_ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_RATE     (RRATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LVL_ON, EV_LVL_OFF, EV_REP_ON, EV_REP_OFF} ev_kind_t;
  typedef struct {
    int       at;
    int       ch;
    ev_kind_t kind;
  } ev_t;

  typedef struct {
    int ch;
    int hold;
    int n_press;
  } vec_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  logic [3:0] exp_level = 4'b0;
  logic [3:0] exp_rep = 4'b0;
  logic [3:0] exp_p;
  logic [3:0] exp_r;
  int         press_cnt[4];
  int         e0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int at, input int ch, input ev_kind_t k);
    ev_t e;
    e.at = at;
    e.ch = ch;
    e.kind = k;
    sb.push_back(e);
  endtask

  // Key pressed for edges 0..hold-1 (relative to e0), released afterwards.
  task automatic push_hold(input int ch, input int base, input int hold);
    int last;
    last = hold + 1;  // last edge at which the FSM still sees the key pressed
    if (last < P_LAT) return;
    push(base + P_LAT, ch, EV_PRESS);
    push(base + P_LAT, ch, EV_LVL_ON);
    if (last >= P_LAT + RDLY) begin
      push(base + P_LAT + RDLY, ch, EV_REP_ON);
      for (int p = P_LAT + RDLY; p <= last; p += RRATE) push(base + p, ch, EV_PRESS);
      push(base + last + 1, ch, EV_REP_OFF);
    end
    push(base + hold + P_LAT, ch, EV_RELEASE);
    push(base + hold + P_LAT, ch, EV_LVL_OFF);
  endtask

  task automatic wait_until(input int abs_cyc);
    while (cyc < abs_cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_entry(input int idx, input int ch, input int hold, input int n_press);
    press_cnt[ch] = 0;
    key_in[ch] = 1'b0;
    e0 = cyc + 1;
    push_hold(ch, e0, hold);
    wait_until(e0 + hold - 1);
    key_in[ch] = 1'b1;
    wait_until(e0 + hold + P_LAT + 4);
    check_int("press_count", press_cnt[ch], n_press);
    $display("entry %0d ch=%0d hold=%0d presses=%0d expected=%0d", idx, ch, hold, press_cnt[ch], n_press);
  endtask

  // Per-cycle monitor: retire due events, then compare every output vector.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      exp_p = 4'b0;
      exp_r = 4'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          case (sb[i].kind)
            EV_PRESS:   exp_p[sb[i].ch] = 1'b1;
            EV_RELEASE: exp_r[sb[i].ch] = 1'b1;
            EV_LVL_ON:  exp_level[sb[i].ch] = 1'b1;
            EV_LVL_OFF: exp_level[sb[i].ch] = 1'b0;
            EV_REP_ON:  exp_rep[sb[i].ch] = 1'b1;
            default:    exp_rep[sb[i].ch] = 1'b0;
          endcase
          sb.delete(i);
        end
      end
      check("key_press", key_press, exp_p);
      check("key_release", key_release, exp_r);
      check("key_level", key_level, exp_level);
      check("key_repeat", key_repeat, exp_rep);
      for (int c = 0; c < 4; c++) if (key_press[c] === 1'b1) press_cnt[c]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{ch: 0, hold: 3,  n_press: 0};
    vecs[1] = '{ch: 1, hold: 4,  n_press: 0};
    vecs[2] = '{ch: 0, hold: 5,  n_press: 1};
    vecs[3] = '{ch: 0, hold: 12, n_press: 1};
    vecs[4] = '{ch: 3, hold: 15, n_press: 2};
    vecs[5] = '{ch: 1, hold: 18, n_press: 3};
    vecs[6] = '{ch: 2, hold: 40, n_press: 10};
    for (int c = 0; c < 4; c++) press_cnt[c] = 0;

    rst = 1'b1;
    key_in = 4'hF;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    wait_until(3);
    rst = 1'b0;
    wait_until(cyc + 20);
    $display("reset: outputs held low for 20 cycles after reset");

    foreach (vecs[i]) run_entry(i, vecs[i].ch, vecs[i].hold, vecs[i].n_press);

    // Bounce on key 1: low 3, high 2, low 3, then high.
    press_cnt[1] = 0;
    key_in[1] = 1'b0;
    e0 = cyc + 1;
    wait_until(e0 + 2);
    key_in[1] = 1'b1;
    wait_until(e0 + 4);
    key_in[1] = 1'b0;
    wait_until(e0 + 7);
    key_in[1] = 1'b1;
    wait_until(e0 + 20);
    check_int("bounce_press_count", press_cnt[1], 0);
    $display("bounce: ch=1 presses=%0d", press_cnt[1]);

    // Release bounce on key 3 while HELD; HELD is re-entered at edge 12.
    press_cnt[3] = 0;
    key_in[3] = 1'b0;
    e0 = cyc + 1;
    push(e0 + 6, 3, EV_PRESS);
    push(e0 + 6, 3, EV_LVL_ON);
    push(e0 + 22, 3, EV_PRESS);
    push(e0 + 22, 3, EV_REP_ON);
    push(e0 + 25, 3, EV_PRESS);
    push(e0 + 28, 3, EV_PRESS);
    push(e0 + 31, 3, EV_PRESS);
    push(e0 + 32, 3, EV_REP_OFF);
    push(e0 + 36, 3, EV_RELEASE);
    push(e0 + 36, 3, EV_LVL_OFF);
    wait_until(e0 + 7);
    key_in[3] = 1'b1;
    wait_until(e0 + 9);
    key_in[3] = 1'b0;
    wait_until(e0 + 29);
    key_in[3] = 1'b1;
    wait_until(e0 + 42);
    check_int("release_bounce_press_count", press_cnt[3], 5);
    $display("release bounce: ch=3 presses=%0d", press_cnt[3]);

    // Keys 0 and 3 together, then reset while both repeat: no release pulse.
    press_cnt[0] = 0;
    press_cnt[3] = 0;
    key_in = 4'b0110;
    e0 = cyc + 1;
    for (int k = 0; k < 4; k += 3) begin
      push(e0 + 6, k, EV_PRESS);
      push(e0 + 6, k, EV_LVL_ON);
      push(e0 + 16, k, EV_PRESS);
      push(e0 + 16, k, EV_REP_ON);
      push(e0 + 19, k, EV_PRESS);
      push(e0 + 20, k, EV_LVL_OFF);
      push(e0 + 20, k, EV_REP_OFF);
    end
    wait_until(e0 + 19);
    rst = 1'b1;
    key_in = 4'hF;
    wait_until(e0 + 21);
    rst = 1'b0;
    wait_until(e0 + 40);
    check_int("simul_press_count0", press_cnt[0], 3);
    check_int("simul_press_count3", press_cnt[3], 3);
    $display("simultaneous+reset: ch0=%0d ch3=%0d presses", press_cnt[0], press_cnt[3]);

    run_entry(7, 3, 5, 1);

    check_int("scoreboard_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
